// File: rtl/msx_sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// msx_sdram_arbiter_if
//  Bundles every requester and SDRAM-controller signal of msx_sdram_arbiter.
//  slave  : arbiter side (requests in, acks/back-pressure/SDRAM commands out)
//  master : requesters + SDRAM controller side (the mirror image)
//
//  CPU      : cpu_req/cpu_we/cpu_addr/cpu_din -> cpu_dout/cpu_ack/cpu_wait_n
//  Download : dl_wr/dl_addr/dl_data           -> dl_wait
//  Disk DMA : dsk_req/dsk_we/dsk_addr/dsk_din -> dsk_dout/dsk_ack
//  SDRAM    : sdram_addr/sdram_din/sdram_we/sdram_rd -> controller,
//             sdram_dout/sdram_ready <- controller
// ---------------------------------------------------------------------------
interface msx_sdram_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              cpu_wait_n;

    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;

    logic              dsk_req;
    logic              dsk_we;
    logic [ADDR_W-1:0] dsk_addr;
    logic [7:0]        dsk_din;
    logic [7:0]        dsk_dout;
    logic              dsk_ack;

    logic [ADDR_W-1:0] sdram_addr;
    logic [7:0]        sdram_din;
    logic              sdram_we;
    logic              sdram_rd;
    logic [7:0]        sdram_dout;
    logic              sdram_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait_n,
        input  dl_wr, dl_addr, dl_data,
        output dl_wait,
        input  dsk_req, dsk_we, dsk_addr, dsk_din,
        output dsk_dout, dsk_ack,
        output sdram_addr, sdram_din, sdram_we, sdram_rd,
        input  sdram_dout, sdram_ready
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait_n,
        output dl_wr, dl_addr, dl_data,
        input  dl_wait,
        output dsk_req, dsk_we, dsk_addr, dsk_din,
        input  dsk_dout, dsk_ack,
        input  sdram_addr, sdram_din, sdram_we, sdram_rd,
        output sdram_dout, sdram_ready
    );
endinterface

// File: rtl/msx_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// msx_sdram_arbiter
//  Shares one 8-bit SDRAM port between CPU slot/mapper accesses, ioctl ROM
//  download writes and disk sector-buffer DMA. One transaction at a time:
//  IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
//  Ports
//   clk    : system clock
//   reset  : asynchronous, active-high
//   bus    : msx_sdram_arbiter_if.slave (all requester and SDRAM signals)
//
//  Parameters
//   ADDR_W     : SDRAM byte-address width
//   DSK_STARVE : consecutive CPU grants tolerated while disk waits
//
//  Build option
//   MSX_SDRAM_ARB_RDCACHE_EN : single-entry CPU read cache. A CPU read that
//   hits skips the SDRAM entirely (IDLE -> DONE). Without the macro no cache
//   storage exists.
//
//  Priority CPU > download > disk, with a starvation guard for disk only.
// ---------------------------------------------------------------------------
module msx_sdram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DSK_STARVE = 4
) (
    input  logic               clk,
    input  logic               reset,
    msx_sdram_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DSK_STARVE + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_CPU, G_DL, G_DSK}      gnt_t;

    // FSM
    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    logic              wait_first_q, wait_first_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    // per-requester pending slots
    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]        cpu_din_q, cpu_din_d;
    logic              dl_pend_q, dl_pend_d;
    logic [ADDR_W-1:0] dl_addr_q, dl_addr_d;
    logic [7:0]        dl_data_q, dl_data_d;
    logic              dsk_pend_q, dsk_pend_d;
    logic              dsk_we_q, dsk_we_d;
    logic [ADDR_W-1:0] dsk_addr_q, dsk_addr_d;
    logic [7:0]        dsk_din_q, dsk_din_d;

    // registered outputs
    logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
    logic [7:0]        sdram_din_q, sdram_din_d;
    logic              sdram_we_q, sdram_we_d;
    logic              sdram_rd_q, sdram_rd_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_wait_n_q, cpu_wait_n_d;
    logic              dl_wait_q, dl_wait_d;
    logic [7:0]        dsk_dout_q, dsk_dout_d;
    logic              dsk_ack_q, dsk_ack_d;

`ifdef MSX_SDRAM_ARB_RDCACHE_EN
    logic              c_valid_q, c_valid_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [7:0]        c_data_q, c_data_d;
    logic              cache_hit;
`endif

    // grant selection (only acted on in IDLE)
    gnt_t              gnt_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_din;
    logic              sel_we;
    logic              gnt_we;
    logic              cpu_done, dl_done, dsk_done;
    logic              starved;

    // A requester's slot frees in its DONE cycle, so a strobe arriving in
    // the ack cycle is accepted; this keeps back-to-back requests pending
    // at the next arbitration point.
    assign cpu_done = (state_q == S_DONE) && (gnt_q == G_CPU);
    assign dl_done  = (state_q == S_DONE) && (gnt_q == G_DL);
    assign dsk_done = (state_q == S_DONE) && (gnt_q == G_DSK);

    assign starved  = dsk_pend_q && (starve_cnt_q == CNT_W'(DSK_STARVE));

    always_comb begin
        gnt_sel = G_NONE;
        if (starved)         gnt_sel = G_DSK;
        else if (cpu_pend_q) gnt_sel = G_CPU;
        else if (dl_pend_q)  gnt_sel = G_DL;
        else if (dsk_pend_q) gnt_sel = G_DSK;
    end

    always_comb begin
        sel_addr = dsk_addr_q;
        sel_din  = dsk_din_q;
        sel_we   = dsk_we_q;
        case (gnt_sel)
            G_CPU: begin
                sel_addr = cpu_addr_q;
                sel_din  = cpu_din_q;
                sel_we   = cpu_we_q;
            end
            G_DL: begin
                sel_addr = dl_addr_q;
                sel_din  = dl_data_q;
                sel_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt_we = dsk_we_q;
        if (gnt_q == G_CPU)     gnt_we = cpu_we_q;
        else if (gnt_q == G_DL) gnt_we = 1'b1;
    end

`ifdef MSX_SDRAM_ARB_RDCACHE_EN
    assign cache_hit = c_valid_q && !cpu_we_q && (c_addr_q == cpu_addr_q);
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        wait_first_d = wait_first_q;
        starve_cnt_d = starve_cnt_q;

        cpu_pend_d = cpu_pend_q;
        cpu_we_d   = cpu_we_q;
        cpu_addr_d = cpu_addr_q;
        cpu_din_d  = cpu_din_q;
        dl_pend_d  = dl_pend_q;
        dl_addr_d  = dl_addr_q;
        dl_data_d  = dl_data_q;
        dsk_pend_d = dsk_pend_q;
        dsk_we_d   = dsk_we_q;
        dsk_addr_d = dsk_addr_q;
        dsk_din_d  = dsk_din_q;

        sdram_addr_d = sdram_addr_q;
        sdram_din_d  = sdram_din_q;
        sdram_we_d   = 1'b0;
        sdram_rd_d   = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        cpu_ack_d    = 1'b0;
        dsk_dout_d   = dsk_dout_q;
        dsk_ack_d    = 1'b0;
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
        c_valid_d = c_valid_q;
        c_addr_d  = c_addr_q;
        c_data_d  = c_data_q;
`endif

        // completion frees the slot; a same-cycle strobe below re-arms it
        if (cpu_done) cpu_pend_d = 1'b0;
        if (dl_done)  dl_pend_d  = 1'b0;
        if (dsk_done) dsk_pend_d = 1'b0;

        if (bus.cpu_req && (!cpu_pend_q || cpu_done)) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = bus.cpu_we;
            cpu_addr_d = bus.cpu_addr;
            cpu_din_d  = bus.cpu_din;
        end
        if (bus.dl_wr && (!dl_pend_q || dl_done)) begin
            dl_pend_d = 1'b1;
            dl_addr_d = bus.dl_addr;
            dl_data_d = bus.dl_data;
        end
        if (bus.dsk_req && (!dsk_pend_q || dsk_done)) begin
            dsk_pend_d = 1'b1;
            dsk_we_d   = bus.dsk_we;
            dsk_addr_d = bus.dsk_addr;
            dsk_din_d  = bus.dsk_din;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.sdram_ready && gnt_sel != G_NONE) begin
                    gnt_d        = gnt_sel;
                    sdram_addr_d = sel_addr;
                    sdram_din_d  = sel_din;
                    sdram_we_d   = sel_we;
                    sdram_rd_d   = !sel_we;
                    state_d      = S_ISSUE;
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
                    // hit decided at grant time so arbitration order is
                    // the same with or without the cache
                    if (gnt_sel == G_CPU && cache_hit) begin
                        sdram_we_d = 1'b0;
                        sdram_rd_d = 1'b0;
                        cpu_dout_d = c_data_q;
                        cpu_ack_d  = 1'b1;
                        state_d    = S_DONE;
                    end
`endif
                    if (gnt_sel == G_DSK)
                        starve_cnt_d = '0;
                    else if (gnt_sel == G_CPU && dsk_pend_q && !starved)
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                state_d      = S_WAIT;
                wait_first_d = 1'b1;
            end
            S_WAIT: begin
                // controller may still show the previous ready level in the
                // first WAIT cycle, so it is not trusted there
                wait_first_d = 1'b0;
                if (!wait_first_q && bus.sdram_ready) begin
                    state_d = S_DONE;
                    if (gnt_q == G_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (!cpu_we_q) cpu_dout_d = bus.sdram_dout;
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
                        if (!cpu_we_q) begin
                            c_valid_d = 1'b1;
                            c_addr_d  = cpu_addr_q;
                            c_data_d  = bus.sdram_dout;
                        end
`endif
                    end
                    if (gnt_q == G_DSK) begin
                        dsk_ack_d = 1'b1;
                        if (!dsk_we_q) dsk_dout_d = bus.sdram_dout;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = G_NONE;
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
                // keep the cache coherent with writes that reached SDRAM;
                // downloads overwrite ROM images wholesale, so drop the entry
                if (gnt_q == G_CPU && gnt_we && c_addr_q == cpu_addr_q)
                    c_data_d = cpu_din_q;
                if (gnt_q == G_DSK && gnt_we && c_addr_q == dsk_addr_q)
                    c_valid_d = 1'b0;
                if (gnt_q == G_DL)
                    c_valid_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (!dsk_pend_q) starve_cnt_d = '0;

        cpu_wait_n_d = !cpu_pend_d;
        dl_wait_d    = dl_pend_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= G_NONE;
            wait_first_q <= 1'b0;
            starve_cnt_q <= '0;
            cpu_pend_q   <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_din_q    <= '0;
            dl_pend_q    <= 1'b0;
            dl_addr_q    <= '0;
            dl_data_q    <= '0;
            dsk_pend_q   <= 1'b0;
            dsk_we_q     <= 1'b0;
            dsk_addr_q   <= '0;
            dsk_din_q    <= '0;
            sdram_addr_q <= '0;
            sdram_din_q  <= '0;
            sdram_we_q   <= 1'b0;
            sdram_rd_q   <= 1'b0;
            cpu_dout_q   <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_wait_n_q <= 1'b1;
            dl_wait_q    <= 1'b0;
            dsk_dout_q   <= '0;
            dsk_ack_q    <= 1'b0;
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
            c_valid_q    <= 1'b0;
            c_addr_q     <= '0;
            c_data_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            wait_first_q <= wait_first_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_din_q    <= cpu_din_d;
            dl_pend_q    <= dl_pend_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            dsk_pend_q   <= dsk_pend_d;
            dsk_we_q     <= dsk_we_d;
            dsk_addr_q   <= dsk_addr_d;
            dsk_din_q    <= dsk_din_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_din_q  <= sdram_din_d;
            sdram_we_q   <= sdram_we_d;
            sdram_rd_q   <= sdram_rd_d;
            cpu_dout_q   <= cpu_dout_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_wait_n_q <= cpu_wait_n_d;
            dl_wait_q    <= dl_wait_d;
            dsk_dout_q   <= dsk_dout_d;
            dsk_ack_q    <= dsk_ack_d;
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
            c_valid_q    <= c_valid_d;
            c_addr_q     <= c_addr_d;
            c_data_q     <= c_data_d;
`endif
        end
    end

    assign bus.sdram_addr = sdram_addr_q;
    assign bus.sdram_din  = sdram_din_q;
    assign bus.sdram_we   = sdram_we_q;
    assign bus.sdram_rd   = sdram_rd_q;
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_wait_n = cpu_wait_n_q;
    assign bus.dl_wait    = dl_wait_q;
    assign bus.dsk_dout   = dsk_dout_q;
    assign bus.dsk_ack    = dsk_ack_q;

endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_msx_sdram_arbiter
//  Directed bench for msx_sdram_arbiter with a small SDRAM controller model:
//  after each command ready drops for busy_len cycles; read data is a fixed
//  function of the address (0x100 -> 0x5A, otherwise addr[7:0] ^ 0x3C).
// ---------------------------------------------------------------------------
module tb_msx_sdram_arbiter;
    localparam int AW = 25;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    msx_sdram_arbiter_if #(.ADDR_W(AW)) bus ();
    msx_sdram_arbiter #(.ADDR_W(AW), .DSK_STARVE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    // ---------------- SDRAM controller model ----------------
    int   cyc = 0;
    int   busy_len = 1;
    int   busy = 0;
    bit   force_low = 1'b0;
    int   rd_cnt = 0;
    int   cmd_addr [$];
    bit   cmd_we   [$];
    int   cmd_din  [$];

    function automatic logic [7:0] rd_data(input int a);
        if (a == 'h100) return 8'h5A;
        return 8'(a) ^ 8'h3C;
    endfunction

    assign bus.sdram_ready = (busy == 0) && !force_low;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sdram_rd || bus.sdram_we) begin
            busy <= busy_len;
            cmd_addr.push_back(int'(bus.sdram_addr));
            cmd_we.push_back(bus.sdram_we);
            cmd_din.push_back(int'(bus.sdram_din));
            if (bus.sdram_rd) begin
                bus.sdram_dout <= rd_data(int'(bus.sdram_addr));
                rd_cnt <= rd_cnt + 1;
            end
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    // ---------------- output monitor ----------------
    int         cpu_acks = 0, dsk_acks = 0, dl_done = 0, wait_low = 0;
    int         cpu_ack_cyc = 0, cpu_at_dsk = 0;
    logic [7:0] cpu_dout_seen = '0, dsk_dout_seen = '0;
    bit         dl_wait_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.cpu_ack) begin
            cpu_acks      <= cpu_acks + 1;
            cpu_ack_cyc   <= cyc;
            cpu_dout_seen <= bus.cpu_dout;
        end
        if (bus.dsk_ack) begin
            dsk_acks      <= dsk_acks + 1;
            cpu_at_dsk    <= cpu_acks;
            dsk_dout_seen <= bus.dsk_dout;
        end
        if (!bus.cpu_wait_n) wait_low <= wait_low + 1;
        dl_wait_prev <= bus.dl_wait;
        if (dl_wait_prev && !bus.dl_wait) dl_done <= dl_done + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int cmd_at(input int i);
        if (i < cmd_addr.size()) return cmd_addr[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input bit we, input int a, input int d);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = AW'(a);
        bus.cpu_din  = 8'(d);
    endtask

    task automatic dl_set(input int a, input int d);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = AW'(a);
        bus.dl_data = 8'(d);
    endtask

    task automatic dsk_set(input bit we, input int a, input int d);
        bus.dsk_req  = 1'b1;
        bus.dsk_we   = we;
        bus.dsk_addr = AW'(a);
        bus.dsk_din  = 8'(d);
    endtask

    task automatic fire();
        tick();
        bus.cpu_req = 1'b0;
        bus.dl_wr   = 1'b0;
        bus.dsk_req = 1'b0;
    endtask

    task automatic wait_cpu(input int target);
        for (int i = 0; i < 200 && cpu_acks < target; i++) tick();
    endtask

    task automatic wait_dsk(input int target);
        for (int i = 0; i < 200 && dsk_acks < target; i++) tick();
    endtask

    task automatic wait_dl(input int target);
        for (int i = 0; i < 200 && dl_done < target; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, a0, d0, l0, r0, c0, w0, n;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.dsk_req = 0; bus.dsk_we = 0; bus.dsk_addr = '0; bus.dsk_din = '0;

        // reset values
        repeat (3) tick();
        chk("rst_wait_n", 32'(bus.cpu_wait_n), 1);
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        chk("rst_dl_wait", 32'(bus.dl_wait), 0);
        chk("rst_dsk_ack", 32'(bus.dsk_ack), 0);
        chk("rst_sd_cmd", 32'({bus.sdram_rd, bus.sdram_we}), 0);
        chk("rst_sd_addr", 32'(bus.sdram_addr), 0);
        chk("rst_cpu_dout", 32'(bus.cpu_dout), 0);
        reset = 1'b0;
        tick();

        // 1: CPU read 0x100, 3 busy cycles
        busy_len = 3;
        a0 = cpu_acks; w0 = wait_low; r0 = rd_cnt; c0 = cmd_addr.size();
        s = cyc;
        cpu_set(0, 'h100, 0);
        fire();
        wait_cpu(a0 + 1);
        tick(); tick();
        chk("t1_acks", 32'(cpu_acks - a0), 1);
        chk("t1_latency", 32'(cpu_ack_cyc - s), 7);
        chk("t1_dout", 32'(cpu_dout_seen), 'h5A);
        chk("t1_wait_low", 32'(wait_low - w0), 7);
        chk("t1_rd_pulses", 32'(rd_cnt - r0), 1);
        chk("t1_cmd_addr", 32'(cmd_at(c0)), 'h100);
        chk("t1_wait_n_hi", 32'(bus.cpu_wait_n), 1);

        // 6: second cpu_req while first in flight is ignored
        busy_len = 2;
        a0 = cpu_acks; c0 = cmd_addr.size();
        cpu_set(0, 'h50, 0);
        fire();
        tick(); tick();
        cpu_set(0, 'h60, 0);
        fire();
        wait_cpu(a0 + 1);
        repeat (12) tick();
        chk("t6_acks", 32'(cpu_acks - a0), 1);
        chk("t6_ncmd", 32'(cmd_addr.size() - c0), 1);
        chk("t6_addr", 32'(cmd_at(c0)), 'h50);

        // 2: simultaneous strobes -> CPU, download, disk
        busy_len = 1;
        a0 = cpu_acks; d0 = dsk_acks; l0 = dl_done; c0 = cmd_addr.size();
        cpu_set(0, 'h10, 0);
        dl_set('h20, 'h22);
        dsk_set(0, 'h30, 0);
        fire();
        chk("t2_dl_wait_hi", 32'(bus.dl_wait), 1);
        wait_dsk(d0 + 1);
        tick();
        chk("t2_ncmd", 32'(cmd_addr.size() - c0), 3);
        chk("t2_first", 32'(cmd_at(c0)), 'h10);
        chk("t2_second", 32'(cmd_at(c0 + 1)), 'h20);
        chk("t2_third", 32'(cmd_at(c0 + 2)), 'h30);
        if (cmd_addr.size() > c0 + 1) begin
            chk("t2_dl_we", 32'(cmd_we[c0 + 1]), 1);
            chk("t2_dl_din", 32'(cmd_din[c0 + 1]), 'h22);
        end
        chk("t2_cpu_acks", 32'(cpu_acks - a0), 1);
        chk("t2_dsk_acks", 32'(dsk_acks - d0), 1);
        chk("t2_dl_done", 32'(dl_done - l0), 1);
        chk("t2_cpu_dout", 32'(cpu_dout_seen), 'h2C);
        chk("t2_dsk_dout", 32'(dsk_dout_seen), 'h0C);
        chk("t2_dl_wait_lo", 32'(bus.dl_wait), 0);

        // 3: disk starvation guard after 4 CPU grants
        busy_len = 1;
        a0 = cpu_acks; d0 = dsk_acks; c0 = cmd_addr.size();
        dsk_set(0, 'h80, 0);
        cpu_set(0, 'h40, 0);
        fire();
        n = 1;
        for (int i = 0; i < 300 && dsk_acks == d0; i++) begin
            if (bus.cpu_ack) begin
                cpu_set(0, 'h40 + n, 0);
                n++;
            end
            tick();
            bus.cpu_req = 1'b0;
        end
        wait_cpu(a0 + 5);
        tick();
        chk("t3_cpu_before_dsk", 32'(cpu_at_dsk - a0), 4);
        chk("t3_dsk_slot", 32'(cmd_at(c0 + 4)), 'h80);
        chk("t3_cpu_after", 32'(cmd_at(c0 + 5)), 'h44);
        chk("t3_cpu_acks", 32'(cpu_acks - a0), 5);

        // 4: reset during WAIT
        busy_len = 10;
        a0 = cpu_acks;
        cpu_set(0, 'h74, 0);
        fire();
        repeat (4) tick();
        reset = 1'b1;
        force_low = 1'b1;
        #1;
        chk("t4_rst_wait_n", 32'(bus.cpu_wait_n), 1);
        chk("t4_rst_ack", 32'(bus.cpu_ack), 0);
        chk("t4_rst_addr", 32'(bus.sdram_addr), 0);
        chk("t4_rst_cmd", 32'({bus.sdram_rd, bus.sdram_we}), 0);
        tick(); tick();
        reset = 1'b0;
        c0 = cmd_addr.size();
        cpu_set(0, 'h78, 0);
        fire();
        repeat (8) tick();
        chk("t4_no_cmd", 32'(cmd_addr.size() - c0), 0);
        chk("t4_no_ack", 32'(cpu_acks - a0), 0);
        chk("t4_wait_n_lo", 32'(bus.cpu_wait_n), 0);
        force_low = 1'b0;
        wait_cpu(a0 + 1);
        tick();
        chk("t4_cmd_after", 32'(cmd_at(c0)), 'h78);
        chk("t4_ack_after", 32'(cpu_acks - a0), 1);

        // 5: repeated read of 0x200, then download write, then read again
        repeat (12) tick();
        busy_len = 1;
        a0 = cpu_acks; r0 = rd_cnt; l0 = dl_done;
        cpu_set(0, 'h200, 0);
        fire();
        wait_cpu(a0 + 1);
        tick();
        s = cyc;
        cpu_set(0, 'h200, 0);
        fire();
        wait_cpu(a0 + 2);
        tick();
        chk("t5_dout", 32'(cpu_dout_seen), 'h3C);
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
        chk("t5_rd_cnt", 32'(rd_cnt - r0), 1);
        chk("t5_hit_latency", 32'(cpu_ack_cyc - s), 2);
`else
        chk("t5_rd_cnt", 32'(rd_cnt - r0), 2);
        chk("t5_latency", 32'(cpu_ack_cyc - s), 5);
`endif
        dl_set('h300, 'h99);
        fire();
        wait_dl(l0 + 1);
        tick();
        cpu_set(0, 'h200, 0);
        fire();
        wait_cpu(a0 + 3);
        tick();
`ifdef MSX_SDRAM_ARB_RDCACHE_EN
        chk("t5_rd_after_inv", 32'(rd_cnt - r0), 2);
`else
        chk("t5_rd_after_dl", 32'(rd_cnt - r0), 3);
`endif
        chk("t5_acks", 32'(cpu_acks - a0), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
